data_store_rx: RTL and testbench

Receive-side counterpart of the transmit data store. It accepts a narrow N-bit stream, reassembles chunks MSB-first into DATA_SIZE-bit words, and buffers up to DEPTH words. It computes the frame word count and a 16-bit ones'-complement checksum. On read_request it replays the stored words one per cycle on a wide output stream. It sits between the link-layer receive path and the consumer logic.

---
 rtl/data_store_rx_if.sv | 31 +++
 rtl/data_store_rx.sv | 167 ++++++++++++++++
 tb/tb_data_store_rx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_store_rx_if.sv
// Bus bundle for data_store_rx: narrow chunk input, wide replay output and frame status.
// The store is the slave; the link-layer/consumer side is the master.
interface data_store_rx_if #(
    parameter int N         = 4,
    parameter int DATA_SIZE = 12
);
    // Handshake: axiiv qualifies axiid on every clock with no backpressure (a frame is a
    // contiguous run of axiiv=1); axiov qualifies axiod, replayed words arrive back to back.
    logic [N-1:0]         axiid;
    logic                 axiiv;
    logic                 read_request;
    logic [15:0]          expected_cksum;
    logic                 axiov;
    logic [DATA_SIZE-1:0] axiod;
    logic [15:0]          data_length;
    logic [15:0]          data_cksum;
    logic                 frame_done;
    logic                 partial;
    logic                 overflow;
    logic                 cksum_ok;

    modport master (
        output axiid, axiiv, read_request, expected_cksum,
        input  axiov, axiod, data_length, data_cksum, frame_done, partial, overflow, cksum_ok
    );

    modport slave (
        input  axiid, axiiv, read_request, expected_cksum,
        output axiov, axiod, data_length, data_cksum, frame_done, partial, overflow, cksum_ok
    );
endinterface

// File: rtl/data_store_rx.sv
// Receive data store: reassembles N-bit chunks MSB-first into words, buffers a frame,
// tracks length and ones'-complement checksum, replays on request. Option: RX_CKSUM_CHECK_EN.
module data_store_rx #(
    parameter int N         = 4,
    parameter int DATA_SIZE = 12,
    parameter int DEPTH     = 32
) (
    input  logic           clk,
    input  logic           rst,
    data_store_rx_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int CPW = DATA_SIZE / N;
    localparam int CCW = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2, READ = 2'd3} state_t;

    state_t               state, state_next;
    logic [CCW-1:0]       cc, cc_base;
    logic [DATA_SIZE-1:0] asm_reg, asm_shift, pad_word, wr_word;
    logic [CW-1:0]        count, count_base, rd_idx;
    logic [15:0]          cksum, cksum_base, cksum_next;
    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic                 axiov_r, frame_done_r, partial_r, overflow_r;
    logic [DATA_SIZE-1:0] axiod_r;

    logic start_frame, take_chunk, end_frame, start_read, read_step;
    logic word_complete, pad_pending, wr_en, room, commit, drop;
    int   pad_shift;

    // End-around carry is folded in the same add, so the running sum is always 16 bits.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        take_chunk  = 1'b0;
        end_frame   = 1'b0;
        start_read  = 1'b0;
        read_step   = 1'b0;
        case (state)
            IDLE: if (bus.axiiv) begin
                start_frame = 1'b1;
                take_chunk  = 1'b1;
                state_next  = RECV;
            end
            RECV: if (bus.axiiv) take_chunk = 1'b1;
                  else begin
                      end_frame  = 1'b1;
                      state_next = DONE;
                  end
            DONE: if (bus.read_request) begin
                start_read = 1'b1;
                state_next = READ;
            end else if (bus.axiiv) begin
                start_frame = 1'b1;
                take_chunk  = 1'b1;
                state_next  = RECV;
            end
            READ: if (rd_idx < count) read_step = 1'b1;
                  else state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A new frame restarts the assembly, count and sum from zero in the same cycle.
    always_comb begin
        cc_base       = start_frame ? '0 : cc;
        asm_shift     = ((start_frame ? '0 : asm_reg) << N) | DATA_SIZE'(bus.axiid);
        word_complete = take_chunk && (cc_base == CCW'(CPW - 1));
        pad_shift     = (CPW - int'(cc)) * N;
        pad_word      = asm_reg << pad_shift;
        pad_pending   = end_frame && (cc != '0);
        wr_en         = word_complete || pad_pending;
        wr_word       = word_complete ? asm_shift : pad_word;
        count_base    = start_frame ? '0 : count;
        cksum_base    = start_frame ? '0 : cksum;
        room          = count_base < CW'(DEPTH);
        commit        = wr_en && room;
        drop          = wr_en && !room;
        cksum_next    = commit ? ones_add(cksum_base, 16'(wr_word)) : cksum_base;
    end

    always_ff @(posedge clk) begin
        if (!rst && commit) mem[count_base[AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cc           <= '0;
            asm_reg      <= '0;
            count        <= '0;
            cksum        <= '0;
            rd_idx       <= '0;
            axiov_r      <= 1'b0;
            axiod_r      <= '0;
            frame_done_r <= 1'b0;
            partial_r    <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            frame_done_r <= end_frame;
            if (start_frame) begin
                partial_r  <= 1'b0;
                overflow_r <= 1'b0;
            end
            if (take_chunk) begin
                asm_reg <= asm_shift;
                cc      <= word_complete ? '0 : cc_base + CCW'(1);
            end
            if (take_chunk || end_frame) begin
                count <= count_base + CW'(commit);
                cksum <= cksum_next;
            end
            if (drop) overflow_r <= 1'b1;
            if (end_frame) begin
                cc        <= '0;
                partial_r <= pad_pending;
            end
            if (start_read) begin
                axiov_r <= 1'b1;
                axiod_r <= mem[0];
                rd_idx  <= CW'(1);
            end else if (read_step) begin
                axiov_r <= 1'b1;
                axiod_r <= mem[rd_idx[AW-1:0]];
                rd_idx  <= rd_idx + CW'(1);
            end else begin
                axiov_r <= 1'b0;
                axiod_r <= '0;
            end
        end
    end

`ifdef RX_CKSUM_CHECK_EN
    logic cksum_ok_r;
    always_ff @(posedge clk) begin
        if (rst)              cksum_ok_r <= 1'b0;
        else if (start_frame) cksum_ok_r <= 1'b0;
        else if (end_frame)   cksum_ok_r <= (cksum_next == bus.expected_cksum);
    end
    assign bus.cksum_ok = cksum_ok_r;
`else
    logic unused_expected;
    assign unused_expected = ^bus.expected_cksum;
    assign bus.cksum_ok    = 1'b0;
`endif

    assign bus.axiov       = axiov_r;
    assign bus.axiod       = axiod_r;
    assign bus.data_length = 16'(count);
    assign bus.data_cksum  = cksum;
    assign bus.frame_done  = frame_done_r;
    assign bus.partial     = partial_r;
    assign bus.overflow    = overflow_r;
    assign dbg_state       = state;
endmodule

// File: tb/tb_data_store_rx.sv
// Directed bench for data_store_rx: a frame-level model predicts status and replay words,
// one negedge process compares them, and literal checks pin the model to known frames.
module tb_data_store_rx;
    localparam int N     = 4;
    localparam int W     = 12;
    localparam int DEPTH = 32;
    localparam int CPW   = W / N;
`ifdef RX_CKSUM_CHECK_EN
    localparam logic CK_EN = 1'b1;
`else
    localparam logic CK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;

    data_store_rx_if #(.N(N), .DATA_SIZE(W)) bus ();

    data_store_rx #(.N(N), .DATA_SIZE(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] frame_words[$];
    logic [N-1:0] chunk_q[$];
    logic         exp_fd     = 1'b0;
    logic         exp_replay = 1'b0;
    logic [15:0]  m_len, m_ck;
    logic         m_part, m_ovf, m_ok;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: group chunks into words, keep the first DEPTH, plain sum then fold carries.
    task automatic build_model(input logic [15:0] ecks);
        int     nw;
        int     word;
        int     idx;
        longint sum;
        nw  = (chunk_q.size() + CPW - 1) / CPW;
        sum = 0;
        frame_words.delete();
        for (int w = 0; w < nw; w++) begin
            word = 0;
            for (int j = 0; j < CPW; j++) begin
                idx  = w * CPW + j;
                word = word * (1 << N) + ((idx < chunk_q.size()) ? int'(chunk_q[idx]) : 0);
            end
            if (w < DEPTH) begin
                frame_words.push_back(W'(word));
                sum += word;
            end
        end
        while (sum > 65535) sum = (sum % 65536) + (sum / 65536);
        m_len  = 16'(frame_words.size());
        m_ck   = 16'(sum);
        m_part = (chunk_q.size() % CPW) != 0;
        m_ovf  = nw > DEPTH;
        m_ok   = CK_EN && (m_ck == ecks);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("frame_done", bus.frame_done, exp_fd);
            if (bus.frame_done) begin
                check("data_length", bus.data_length, m_len);
                check("data_cksum", bus.data_cksum, m_ck);
                check("partial", bus.partial, m_part);
                check("overflow", bus.overflow, m_ovf);
                check("cksum_ok", bus.cksum_ok, m_ok);
            end
            if (exp_replay && exp_q.size() > 0) begin
                check("axiov_word", bus.axiov, 1);
                check("axiod", bus.axiod, exp_q[0]);
                got_q.push_back(bus.axiod);
                void'(exp_q.pop_front());
            end else begin
                check("axiov_quiet", bus.axiov, 0);
            end
        end
    end

    task automatic run_frame(input logic [15:0] ecks);
        build_model(ecks);
        bus.expected_cksum = ecks;
        foreach (chunk_q[i]) begin
            bus.axiiv = 1'b1;
            bus.axiid = chunk_q[i];
            @(posedge clk); #1;
        end
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        @(posedge clk); #1;
        exp_fd = 1'b1;
        @(posedge clk); #1;
        exp_fd = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_axiov"}, bus.axiov, 0);
        check({tag, "_axiod"}, bus.axiod, 0);
        check({tag, "_len"}, bus.data_length, 0);
        check({tag, "_cksum"}, bus.data_cksum, 0);
        check({tag, "_fd"}, bus.frame_done, 0);
        check({tag, "_partial"}, bus.partial, 0);
        check({tag, "_overflow"}, bus.overflow, 0);
        check({tag, "_cksum_ok"}, bus.cksum_ok, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic check_status(input string tag, input logic [15:0] len, input logic [15:0] ck,
                                input logic part, input logic ovf);
        check({tag, "_len"}, bus.data_length, len);
        check({tag, "_cksum"}, bus.data_cksum, ck);
        check({tag, "_partial"}, bus.partial, part);
        check({tag, "_overflow"}, bus.overflow, ovf);
    endtask

    // abort_at >= 0 asserts rst while replay word abort_at is on the output.
    task automatic do_read(input int abort_at, input logic poke);
        bus.read_request = 1'b1;
        if (poke) begin
            bus.axiiv = 1'b1;
            bus.axiid = 4'h5;
        end
        @(posedge clk); #1;
        bus.read_request = 1'b0;
        exp_q = frame_words;
        got_q.delete();
        exp_replay = 1'b1;
        if (poke) begin
            @(posedge clk); #1;
            bus.axiiv = 1'b0;
            bus.axiid = '0;
        end
        if (abort_at >= 0) begin
            repeat (abort_at) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_replay = 1'b0;
            exp_q.delete();
            frame_words.delete();
            check_zero("rst_read");
        end else begin
            for (int i = 0; i < DEPTH + 4 && exp_q.size() > 0; i++) @(posedge clk);
            check("replay_drain", exp_q.size(), 0);
            exp_q.delete();
            @(posedge clk); #1;
            exp_replay = 1'b0;
        end
    endtask

    task automatic load_basic();
        chunk_q.delete();
        for (int i = 1; i <= 15; i++) chunk_q.push_back(N'(i));
    endtask

    task automatic load_abc111();
        chunk_q = '{4'hA, 4'hB, 4'hC, 4'h1, 4'h1, 4'h1};
    endtask

    initial begin
        bus.axiiv          = 1'b0;
        bus.axiid          = '0;
        bus.read_request   = 1'b0;
        bus.expected_cksum = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        load_basic();
        run_frame(16'h25AD);
        check_status("basic", 16'd5, 16'h25AD, 1'b0, 1'b0);
        check("basic_cksum_ok", bus.cksum_ok, CK_EN);
        do_read(-1, 1'b0);
        check("basic_n", got_q.size(), 5);
        check("basic_w0", got_q[0], 12'h123);
        check("basic_w2", got_q[2], 12'h789);
        check("basic_w4", got_q[4], 12'hDEF);
        check_status("basic_hold", 16'd5, 16'h25AD, 1'b0, 1'b0);
        check("basic_idle", dbg_state, 0);

        chunk_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_frame(16'h0000);
        check_status("partial", 16'd2, 16'h0523, 1'b1, 1'b0);
        do_read(-1, 1'b0);
        check("partial_w0", got_q[0], 12'h123);
        check("partial_w1", got_q[1], 12'h400);

        chunk_q.delete();
        for (int i = 0; i < 51; i++) chunk_q.push_back(4'hF);
        run_frame(16'h0000);
        check_status("wrap", 16'h0011, 16'h0FF0, 1'b0, 1'b0);
        do_read(-1, 1'b0);

        chunk_q.delete();
        for (int i = 0; i < 33; i++) begin
            chunk_q.push_back(4'h0);
            chunk_q.push_back(4'h0);
            chunk_q.push_back(4'h1);
        end
        run_frame(16'h0000);
        check_status("ovf", 16'd32, 16'h0020, 1'b0, 1'b1);
        do_read(-1, 1'b0);
        check("ovf_n", got_q.size(), 32);

        load_basic();
        run_frame(16'h25AC);
        check("bad_cksum_ok", bus.cksum_ok, 0);
        // read_request and axiiv together in DONE: the read wins, the chunk is dropped.
        do_read(-1, 1'b1);
        check("poke_n", got_q.size(), 5);
        check_status("poke_hold", 16'd5, 16'h25AD, 1'b0, 1'b0);
        check("poke_idle", dbg_state, 0);

        for (int i = 1; i <= 5; i++) begin
            bus.axiiv = 1'b1;
            bus.axiid = N'(i);
            @(posedge clk); #1;
        end
        rst       = 1'b1;
        bus.axiiv = 1'b0;
        bus.axiid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("rst_recv");
        load_abc111();
        run_frame(16'h0BCD);
        check_status("after_recv_rst", 16'd2, 16'h0BCD, 1'b0, 1'b0);
        check("after_recv_rst_ok", bus.cksum_ok, CK_EN);
        do_read(-1, 1'b0);
        check("after_recv_rst_w0", got_q[0], 12'hABC);

        load_basic();
        run_frame(16'h25AD);
        do_read(2, 1'b0);
        check("rst_read_seen", got_q.size(), 2);
        load_abc111();
        run_frame(16'h0000);
        check_status("after_read_rst", 16'd2, 16'h0BCD, 1'b0, 1'b0);
        do_read(-1, 1'b0);
        check("after_read_rst_w1", got_q[1], 12'h111);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1000000 ns");
        $fatal(1);
    end
endmodule
